seq_det_scheduler: RTL and testbench

- Shares a single programmable bit-serial sequence detector among NREQ requesters.
- Each requester presents a DATA_W-bit word. A round-robin arbiter grants one requester at a time. The controller serializes the granted word MSB-first into the detector and counts pattern matches, with overlap allowed.
- The count is returned to the consumer over a valid/ready response channel.
- The block sits between the serial-pattern test sources and the result collector, and owns the detector's pattern configuration.

---
 rtl/seq_det_scheduler.sv | 163 ++++++++++++++++
 tb/tb_seq_det_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: a round-robin arbiter that shares one programmable
// bit-serial pattern detector among NREQ requesters. The granted word is
// shifted MSB-first through the detector. Overlapping matches are counted,
// and the count is returned on a valid/ready response channel.
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid[k] && req_ready[k]. A response transfers on a rising edge where
// rsp_valid && rsp_ready. Once rsp_valid is raised, it and rsp_id/rsp_count/
// rsp_hit hold until that edge. busy exposes the FSM (state != IDLE).
module seq_det_scheduler #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 16,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 5,
   localparam int ID_W  = $clog2(NREQ),
   localparam int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [PAT_W-1:0]       cfg_pattern,
   input  logic [LEN_W-1:0]       cfg_len,
   output logic                   cfg_err,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [CNT_W-1:0]       rsp_count,
   output logic                   rsp_hit,
   output logic                   busy,
   output logic                   det_bit,
   output logic                   det_match
);

   localparam int BC_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   job_id;
   logic [ID_W-1:0]   winner;
   logic              found;
   logic [DATA_W-1:0] shreg;
   logic [PAT_W-2:0]  hist;        // previous PAT_W-1 bits; newest bit completes the window
   logic [PAT_W-1:0]  hist_next;
   logic [PAT_W-1:0]  pattern;
   logic [PAT_W-1:0]  len_mask;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  seen;        // bits seen before this one, saturating at PAT_W
   logic [LEN_W-1:0]  cfg_len_sat;
   logic [BC_W-1:0]   bitcnt;
   logic [CNT_W-1:0]  count;

   // Round-robin search: first valid requester at or above rr_ptr, with wrap.
   always_comb begin : arb
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // Grant is combinational and only offered while idle.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready = NREQ'(1) << winner;
   end

   // Detector datapath: window compare over the active pattern length.
   always_comb begin
      hist_next = {hist, shreg[DATA_W-1]};
      for (int i = 0; i < PAT_W; i++) len_mask[i] = (i < int'(len));
      det_bit   = (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;
      det_match = (state == SHIFT) && (len != '0) &&
                  (int'(seen) + 1 >= int'(len)) &&
                  (((hist_next ^ pattern) & len_mask) == '0);
      cfg_len_sat = (int'(cfg_len) > PAT_W) ? LEN_W'(PAT_W) : cfg_len;
      busy        = (state != IDLE);
   end

   // Control FSM, configuration registers and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         job_id    <= '0;
         pattern   <= '0;
         len       <= '0;
         shreg     <= '0;
         hist      <= '0;
         seen      <= '0;
         bitcnt    <= '0;
         count     <= '0;
         cfg_err   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_count <= '0;
         rsp_hit   <= 1'b0;
      end else begin
         // A config write is only safe in an idle cycle that does not start a job.
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (state == IDLE && !found) begin
               pattern <= cfg_pattern;
               len     <= cfg_len_sat;
            end else begin
               cfg_err <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (found) begin
                  shreg  <= req_data[winner*DATA_W +: DATA_W];
                  job_id <= winner;
                  hist   <= '0;
                  seen   <= '0;
                  count  <= '0;
                  bitcnt <= BC_W'(DATA_W);
                  rr_ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               shreg  <= shreg << 1;
               hist   <= hist_next[PAT_W-2:0];
               bitcnt <= bitcnt - 1'b1;
               if (seen != LEN_W'(PAT_W)) seen <= seen + 1'b1;
               if (det_match) count <= count + 1'b1;
               if (bitcnt == BC_W'(1)) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_id    <= job_id;
                  rsp_count <= count + CNT_W'(det_match);
                  rsp_hit   <= (count != '0) || det_match;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed testbench for seq_det_scheduler (NREQ=4, DATA_W=16, PAT_W=4, CNT_W=5).
module tb_seq_det_scheduler;

   localparam int NREQ   = 4;
   localparam int DATA_W = 16;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_pattern;
   logic [2:0]  cfg_len;
   logic        cfg_err;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [4:0]  rsp_count;
   logic        rsp_hit;
   logic        busy;
   logic        det_bit;
   logic        det_match;

   int tests_run;
   int tests_failed;

   seq_det_scheduler #(
      .NREQ(4), .DATA_W(16), .PAT_W(4), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(cfg_err),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_count(rsp_count), .rsp_hit(rsp_hit), .busy(busy),
      .det_bit(det_bit), .det_match(det_match)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
      $fatal(1, "watchdog");
   end

   // Driver: configuration write in an idle cycle, expected to be accepted.
   task automatic do_cfg(input logic [3:0] p, input logic [2:0] l);
      @(negedge clk);
      req_valid   = '0;
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      @(negedge clk);
      cfg_we = 1'b0;
      tests_run++;
      if (cfg_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL cfg_accept: cfg_err=%b required 0", cfg_err);
      end
   endtask

   // Driver: one full job from requester k with immediate response accept.
   // cfg_at >= 0 injects a (rejected) cfg write at that SHIFT cycle (0 = grant cycle).
   task automatic run_job(input int k, input logic [15:0] data, input int exp_cnt,
                          input int cfg_at, input logic [3:0] cp, input logic [2:0] cl);
      int   lat;
      int   mcnt;
      logic got;
      logic [3:0] exp_rdy;
      @(negedge clk);
      req_data[k*DATA_W +: DATA_W] = data;
      req_valid    = '0;
      req_valid[k] = 1'b1;
      rsp_ready    = 1'b0;
      if (cfg_at == 0) begin
         cfg_we = 1'b1; cfg_pattern = cp; cfg_len = cl;
      end
      #1;
      exp_rdy = '0;
      exp_rdy[k] = 1'b1;
      tests_run++;
      if (req_ready !== exp_rdy) begin
         tests_failed++;
         $display("FAIL job_grant: req_ready=%b required %b", req_ready, exp_rdy);
      end
      @(posedge clk);
      lat = 0; mcnt = 0; got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = '0;
         if (cfg_at > 0 && c == cfg_at) begin
            cfg_we = 1'b1; cfg_pattern = cp; cfg_len = cl;
         end
         if (cfg_at >= 0 && c == cfg_at + 1) begin
            cfg_we = 1'b0;
            tests_run++;
            if (cfg_err !== 1'b1) begin
               tests_failed++;
               $display("FAIL cfg_err_pulse: cfg_err=%b required 1", cfg_err);
            end
         end
         if (cfg_at >= 0 && c == cfg_at + 2) begin
            tests_run++;
            if (cfg_err !== 1'b0) begin
               tests_failed++;
               $display("FAIL cfg_err_single: cfg_err=%b required 0", cfg_err);
            end
         end
         if (c <= DATA_W) begin
            tests_run++;
            if (det_bit !== data[DATA_W-c]) begin
               tests_failed++;
               $display("FAIL det_bit[%0d]: det_bit=%b required %b", c, det_bit, data[DATA_W-c]);
            end
            if (det_match === 1'b1) mcnt++;
         end
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            lat = c;
         end
      end
      tests_run++;
      if (lat != 17) begin
         tests_failed++;
         $display("FAIL rsp_latency: rsp_valid after %0d cycles required 17", lat);
      end
      tests_run++;
      if (rsp_id !== 2'(k)) begin
         tests_failed++;
         $display("FAIL rsp_id: rsp_id=%0d required %0d", rsp_id, k);
      end
      tests_run++;
      if (rsp_count !== 5'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL rsp_count: rsp_count=%0d required %0d (data %h)", rsp_count, exp_cnt, data);
      end
      tests_run++;
      if (rsp_hit !== (exp_cnt != 0)) begin
         tests_failed++;
         $display("FAIL rsp_hit: rsp_hit=%b required %b", rsp_hit, (exp_cnt != 0));
      end
      tests_run++;
      if (mcnt != exp_cnt) begin
         tests_failed++;
         $display("FAIL det_match_pulses: counted %0d required %0d", mcnt, exp_cnt);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL job_done: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({busy, rsp_valid, req_ready, cfg_err, det_bit, det_match, rsp_id, rsp_count, rsp_hit} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b rsp_valid=%b req_ready=%b cfg_err=%b det=%b%b id=%0d cnt=%0d hit=%b required all 0",
                  busy, rsp_valid, req_ready, cfg_err, det_bit, det_match, rsp_id, rsp_count, rsp_hit);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_match;
      do_cfg(4'b1011, 3'd4);
      run_job(0, 16'hB6DB, 5, -1, 4'b0, 3'd0);
   endtask

   task automatic test_overlap;
      do_cfg(4'b0011, 3'd2);
      run_job(1, 16'hFFFF, 15, -1, 4'b0, 3'd0);
      run_job(2, 16'h0000, 0, -1, 4'b0, 3'd0);
      do_cfg(4'b0011, 3'd0);
      run_job(3, 16'hFFFF, 0, -1, 4'b0, 3'd0);
   endtask

   task automatic test_cfg_reject;
      do_cfg(4'b1011, 3'd4);
      run_job(0, 16'hB6DB, 5, 4, 4'b0011, 3'd2);   // write during SHIFT rejected
      run_job(1, 16'hB6DB, 5, -1, 4'b0, 3'd0);     // next job still on old pattern
      do_cfg(4'b1111, 3'd7);                       // len 7 stored as 4
      run_job(2, 16'hFFFF, 13, -1, 4'b0, 3'd0);
      run_job(3, 16'hFFFF, 13, 0, 4'b0000, 3'd4);  // write with grant rejected
      run_job(0, 16'hFFFF, 13, -1, 4'b0, 3'd0);
   endtask

   task automatic test_backpressure;
      logic got;
      do_cfg(4'b1111, 3'd4);
      @(negedge clk);
      req_data[15:0] = 16'hFFFF;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0010;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (rsp_valid === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL bp_rsp_timeout: rsp_valid=%b required 1 within 40 cycles", rsp_valid);
      end
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_count !== 5'd13 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: valid=%b id=%0d cnt=%0d req_ready=%b required 1 0 13 0000",
                     i, rsp_valid, rsp_id, rsp_count, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010) begin
         tests_failed++;
         $display("FAIL bp_release: valid=%b busy=%b req_ready=%b required 0 0 0010",
                  rsp_valid, busy, req_ready);
      end
      req_valid = '0;
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_single: valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_round_robin;
      int         exp_g[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
      int         g;
      logic [3:0] exp_rdy;
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_data  = {4{16'h1234}};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      g = 0;
      for (int cyc = 0; cyc < 400 && g < 9; cyc++) begin
         #1;
         if (busy === 1'b0) begin
            exp_rdy = '0;
            exp_rdy[exp_g[g]] = 1'b1;
            tests_run++;
            if (req_ready !== exp_rdy) begin
               tests_failed++;
               $display("FAIL rr_grant[%0d]: req_ready=%b required %b", g, req_ready, exp_rdy);
            end
            g++;
            if (g == 7) begin
               @(negedge clk);
               req_valid = 4'b1010;
            end
         end else begin
            tests_run++;
            if (req_ready !== 4'b0000) begin
               tests_failed++;
               $display("FAIL rr_busy_ready: req_ready=%b required 0000", req_ready);
            end
         end
         @(negedge clk);
      end
      tests_run++;
      if (g != 9) begin
         tests_failed++;
         $display("FAIL rr_timeout: %0d grants seen required 9", g);
      end
      req_valid = '0;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic got;
      do_cfg(4'b0011, 3'd2);
      @(negedge clk);
      req_data[32 +: 16] = 16'hFFFF;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = '0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         tests_failed++;
         $display("FAIL midrst_state: busy=%b valid=%b req_ready=%b required 0 0 0000",
                  busy, rsp_valid, req_ready);
      end
      got = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) got = 1'b1;
      end
      tests_run++;
      if (got !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_no_rsp: aborted job responded=%b required 0", got);
      end
      req_data  = {4{16'hFFFF}};
      req_valid = 4'hF;
      #1;
      tests_run++;
      if (req_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL midrst_rr: req_ready=%b required 0001", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (rsp_valid === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      tests_run++;
      if (!got || rsp_id !== 2'd0 || rsp_count !== 5'd0 || rsp_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_len0: got=%b id=%0d cnt=%0d hit=%b required 1 0 0 0",
                  got, rsp_id, rsp_count, rsp_hit);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // Test sequence and summary
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      cfg_we       = 1'b0;
      cfg_pattern  = '0;
      cfg_len      = '0;
      req_valid    = '0;
      req_data     = '0;
      rsp_ready    = 1'b0;
      test_reset();
      test_basic_match();
      test_overlap();
      test_cfg_reject();
      test_backpressure();
      test_round_robin();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
